// File: rtl/sti_dac_multi.sv
// -----------------------------------------------------------------------------
// sti_dac_multi
//
// Serial-transmit / data-arrange engine for the display-memory path.
// Each accepted frame (1/2, 1, 3/2 or 2 data-widths) is shifted out one bit
// per cycle. The serial stream is packed MSB-first into bytes, and each byte
// is written to one of BANKS odd/even bank pairs using a checkerboard
// interleave. On pi_end the remaining bytes are zero-filled, and then
// oem_finish is raised.
//
// Ports
//   clk, reset           clock and asynchronous active-high reset
//   load                 frame request, accepted only in IDLE
//   pi_data              parallel data word
//   pi_length            00 = DW/2, 01 = DW, 10 = 3DW/2, 11 = 2DW bits
//   pi_fill              long frames: 0 = data low and zeros high, 1 = reverse
//   pi_msb               1 = MSB-first, 0 = LSB-first
//   pi_low               half frames: 1 = upper half of pi_data
//   pi_end               end of input, sampled in IDLE when load = 0
//   busy                 high in SHIFT or FILL
//   so_data, so_valid    serial bit and its qualifier
//   oem_dataout          byte being written
//   oem_addr             word address within the selected bank
//   odd_wr, even_wr      one-hot, single-cycle bank write strobes
//   oem_finish           sticky done flag
// -----------------------------------------------------------------------------
module sti_dac_multi #(
  parameter int DW        = 16,
  parameter int BANKS     = 4,
  parameter int WORDS     = 32,
  parameter int ROW_BYTES = 8,
  localparam int AW       = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DW-1:0]    pi_data,
  input  logic [1:0]       pi_length,
  input  logic             pi_fill,
  input  logic             pi_msb,
  input  logic             pi_low,
  input  logic             pi_end,
  output logic             busy,
  output logic             so_data,
  output logic             so_valid,
  output logic [7:0]       oem_dataout,
  output logic [AW-1:0]    oem_addr,
  output logic [BANKS-1:0] odd_wr,
  output logic [BANKS-1:0] even_wr,
  output logic             oem_finish
);

  localparam int TOTAL = BANKS * 2 * WORDS;       // bytes across all banks
  localparam int BW    = $clog2(TOTAL) + 1;       // byte index, can reach TOTAL
  localparam int CW    = $clog2(2 * DW) + 1;      // frame bit counter
  localparam int RB    = $clog2(ROW_BYTES);       // byte-index bit holding the row parity

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FILL, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [2*DW-1:0]     r_sreg;
  logic [CW-1:0]       r_cnt;
  logic [2:0]          r_bitcnt;
  logic [6:0]          r_acc;
  logic [BW-1:0]       r_b;
  logic                r_finish;
  logic [7:0]          r_dataout;
  logic [AW-1:0]       r_addr;
  logic [BANKS-1:0]    r_odd, r_even;

  logic [2*DW-1:0]     w_frame, w_frame_rev, w_sreg_init;
  logic [CW-1:0]       w_len;
  logic                w_load, w_wr_en, w_so_bit, w_row;
  logic [7:0]          w_wr_byte;
  logic [BW-1:0]       w_bank;
  logic [BANKS-1:0]    w_bank_oh;

  // The outgoing bit is always the top of the shift register. LSB-first
  // frames are bit-reversed at load time, so shifting is always to the left.
  assign w_so_bit  = r_sreg[2*DW-1];
  assign w_row     = r_b[RB];
  assign w_bank    = r_b >> (AW + 1);
  assign w_bank_oh = BANKS'(1) << w_bank;

  // Build the frame in the low N bits, then align it for transmission.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // leaves a variable unassigned, which would infer a latch.
    w_frame     = '0;
    w_frame_rev = '0;
    w_len       = '0;
    case (pi_length)
      2'b00: begin
        w_frame[DW/2-1:0] = pi_low ? pi_data[DW-1:DW/2] : pi_data[DW/2-1:0];
        w_len = CW'(DW / 2);
      end
      2'b01: begin
        w_frame[DW-1:0] = pi_data;
        w_len = CW'(DW);
      end
      2'b10: begin
        if (pi_fill) w_frame[DW+DW/2-1:DW/2] = pi_data;
        else         w_frame[DW-1:0]         = pi_data;
        w_len = CW'(DW + DW / 2);
      end
      default: begin
        if (pi_fill) w_frame[2*DW-1:DW] = pi_data;
        else         w_frame[DW-1:0]    = pi_data;
        w_len = CW'(2 * DW);
      end
    endcase
    for (int i = 0; i < 2 * DW; i++) w_frame_rev[i] = w_frame[2*DW-1-i];
    // MSB-first moves F[N-1] to the top. A full reversal puts F[0] on top.
    w_sreg_init = pi_msb ? (w_frame << (CW'(2 * DW) - w_len)) : w_frame_rev;
  end

  // Next-state logic and byte-write requests.
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_wr_en   = 1'b0;
    w_wr_byte = '0;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_load = 1'b1;
          w_next = S_SHIFT;
        end else if (pi_end) begin
          if (r_b == BW'(TOTAL)) begin
            w_next = S_DONE;
          end else begin
            // The first zero byte is written at the same edge that starts the fill.
            w_wr_en = 1'b1;
            w_next  = (r_b == BW'(TOTAL - 1)) ? S_DONE : S_FILL;
          end
        end
      end
      S_SHIFT: begin
        if (r_cnt == CW'(1)) w_next = S_IDLE;
        if (r_bitcnt == 3'd7 && r_b != BW'(TOTAL)) begin
          w_wr_en   = 1'b1;
          w_wr_byte = {r_acc, w_so_bit};
        end
      end
      S_FILL: begin
        w_wr_en = (r_b != BW'(TOTAL));
        if (r_b >= BW'(TOTAL - 1)) w_next = S_DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sreg    <= '0;
      r_cnt     <= '0;
      r_bitcnt  <= '0;
      r_acc     <= '0;
      r_b       <= '0;
      r_finish  <= 1'b0;
      r_dataout <= '0;
      r_addr    <= '0;
      r_odd     <= '0;
      r_even    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // right-hand side below reads the value from before this edge.
      r_odd  <= '0;
      r_even <= '0;
      if (w_load) begin
        r_sreg   <= w_sreg_init;
        r_cnt    <= w_len;
        r_bitcnt <= '0;
      end else if (r_state == S_SHIFT) begin
        r_sreg   <= r_sreg << 1;
        r_cnt    <= r_cnt - CW'(1);
        r_bitcnt <= r_bitcnt + 3'd1;
        r_acc    <= {r_acc[5:0], w_so_bit};
      end
      if (w_wr_en) begin
        r_dataout <= w_wr_byte;
        r_addr    <= r_b[AW:1];
        // Checkerboard: the odd/even choice flips on every byte and again on every row.
        if (r_b[0] ^ w_row) r_even <= w_bank_oh;
        else                r_odd  <= w_bank_oh;
        r_b <= r_b + BW'(1);
      end
      if (r_state == S_DONE) r_finish <= 1'b1;
    end
  end

  assign busy        = (r_state == S_SHIFT) || (r_state == S_FILL);
  assign so_valid    = (r_state == S_SHIFT);
  assign so_data     = (r_state == S_SHIFT) && w_so_bit;
  assign oem_dataout = r_dataout;
  assign oem_addr    = r_addr;
  assign odd_wr      = r_odd;
  assign even_wr     = r_even;
  assign oem_finish  = r_finish;

endmodule

// File: tb/tb_sti_dac_multi.sv
// -----------------------------------------------------------------------------
// tb_sti_dac_multi
//
// Self-checking bench for sti_dac_multi (DW=16, BANKS=4, WORDS=32,
// ROW_BYTES=8). A reference model turns each accepted frame into a list of
// expected serial bits and expected byte writes, each tagged with the clock
// count at which it must be seen. A negedge monitor compares the DUT
// against these lists.
// -----------------------------------------------------------------------------
module tb_sti_dac_multi;

  localparam int DW        = 16;
  localparam int BANKS     = 4;
  localparam int WORDS     = 32;
  localparam int ROW_BYTES = 8;
  localparam int AW        = $clog2(WORDS);
  localparam int TOTAL     = BANKS * 2 * WORDS;

  logic             clk = 1'b0;
  logic             reset;
  logic             load;
  logic [DW-1:0]    pi_data;
  logic [1:0]       pi_length;
  logic             pi_fill, pi_msb, pi_low, pi_end;
  logic             busy, so_data, so_valid, oem_finish;
  logic [7:0]       oem_dataout;
  logic [AW-1:0]    oem_addr;
  logic [BANKS-1:0] odd_wr, even_wr;

  sti_dac_multi #(.DW(DW), .BANKS(BANKS), .WORDS(WORDS), .ROW_BYTES(ROW_BYTES)) dut (
    .clk(clk), .reset(reset), .load(load), .pi_data(pi_data),
    .pi_length(pi_length), .pi_fill(pi_fill), .pi_msb(pi_msb),
    .pi_low(pi_low), .pi_end(pi_end), .busy(busy), .so_data(so_data),
    .so_valid(so_valid), .oem_dataout(oem_dataout), .oem_addr(oem_addr),
    .odd_wr(odd_wr), .even_wr(even_wr), .oem_finish(oem_finish)
  );

  always #5 clk = ~clk;

  // ec counts rising edges. A value observed at a negedge belongs to the
  // cycle that follows edge number ec.
  int ec = 0;
  always @(posedge clk) ec <= ec + 1;

  typedef struct {
    int   ec;
    logic val;
  } bit_t;

  typedef struct {
    int               ec;
    logic [BANKS-1:0] odd;
    logic [BANKS-1:0] even;
    logic [AW-1:0]    addr;
    logic [7:0]       data;
  } wr_t;

  bit_t exp_bits[$];
  wr_t  exp_wr[$];
  int   b_model = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Byte b to bank location: bank = b / (2*WORDS), addr = (b mod 2*WORDS) / 2,
  // and the odd bank is used when the parity of b equals the row parity.
  function automatic wr_t map_byte(input int b, input int at_ec, input logic [7:0] d);
    wr_t w;
    int  bank, row;
    bank   = b / (2 * WORDS);
    row    = (b / ROW_BYTES) % 2;
    w.ec   = at_ec;
    w.odd  = '0;
    w.even = '0;
    w.addr = AW'((b % (2 * WORDS)) / 2);
    w.data = d;
    if ((b % 2) == row) w.odd[bank] = 1'b1;
    else                w.even[bank] = 1'b1;
    return w;
  endfunction

  // Expected bits and byte writes for a frame whose load is sampled at edge k.
  task automatic model_frame(input int k, input logic [DW-1:0] d, input logic [1:0] len,
                             input logic fill, input logic msb, input logic low);
    logic [63:0] f;
    logic [7:0]  acc;
    logic        v;
    int          n;
    acc = '0;
    case (len)
      2'd0: begin
        n = DW / 2;
        f = low ? 64'(d / (1 << (DW / 2))) : 64'(d % (1 << (DW / 2)));
      end
      2'd1: begin
        n = DW;
        f = 64'(d);
      end
      default: begin
        n = (len == 2'd2) ? (3 * DW / 2) : (2 * DW);
        f = fill ? (64'(d) << (n - DW)) : 64'(d);
      end
    endcase
    for (int i = 0; i < n; i++) begin
      v = msb ? f[n-1-i] : f[i];
      exp_bits.push_back('{ec: k + i, val: v});
      acc = {acc[6:0], v};
      if (i % 8 == 7 && b_model < TOTAL) begin
        exp_wr.push_back(map_byte(b_model, k + i + 1, acc));
        b_model++;
      end
    end
  endtask

  // Monitor: every expected bit and write must appear exactly at its cycle,
  // and nothing else may appear.
  always @(negedge clk) begin
    if (!reset) begin
      if (exp_bits.size() > 0 && exp_bits[0].ec == ec) begin
        check("so_valid", so_valid, 1'b1);
        check("so_data", so_data, exp_bits[0].val);
        void'(exp_bits.pop_front());
      end else if (so_valid) begin
        check("so_valid_spurious", so_valid, 1'b0);
      end
      if (exp_wr.size() > 0 && exp_wr[0].ec == ec) begin
        check("wr_strobe", {odd_wr, even_wr}, {exp_wr[0].odd, exp_wr[0].even});
        check("wr_addr", oem_addr, exp_wr[0].addr);
        check("wr_data", oem_dataout, exp_wr[0].data);
        void'(exp_wr.pop_front());
      end else if ((|odd_wr) || (|even_wr)) begin
        check("wr_spurious", {odd_wr, even_wr}, '0);
      end
    end
  end

  // Called at a negedge while the DUT is idle. Returns at the negedge just
  // before the earliest edge at which the next load can be sampled.
  task automatic send(input logic [DW-1:0] d, input logic [1:0] len, input logic fill,
                      input logic msb, input logic low, input logic poke);
    int k, n;
    n = (int'(len) + 1) * DW / 2;
    k = ec + 1;
    load = 1'b1; pi_data = d; pi_length = len; pi_fill = fill; pi_msb = msb; pi_low = low;
    model_frame(k, d, len, fill, msb, low);
    @(negedge clk);
    load = 1'b0;
    pi_data = DW'($urandom);
    pi_length = 2'($urandom);
    check("busy_on", busy, 1'b1);
    for (int i = 0; i < n; i++) begin
      if (poke && i == n / 2) begin
        load = 1'b1;
        pi_data = ~d;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    check("busy_off", busy, 1'b0);
  endtask

  task automatic send_random(input logic poke);
    send(DW'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), poke);
  endtask

  // pi_end with zero-fill of the rest, then the sticky finish flag.
  task automatic do_end();
    int m, nwr, fin;
    m = ec + 1;
    pi_end = 1'b1;
    nwr = 0;
    while (b_model < TOTAL) begin
      exp_wr.push_back(map_byte(b_model, m + nwr, 8'h00));
      b_model++;
      nwr++;
    end
    fin = (nwr > 0) ? (m + nwr) : (m + 1);
    @(negedge clk);
    pi_end = 1'b0;
    if (nwr > 1) check("busy_fill", busy, 1'b1);
    while (ec < fin - 1) @(negedge clk);
    check("finish_before", oem_finish, 1'b0);
    @(negedge clk);
    check("finish_rise", oem_finish, 1'b1);
    check("busy_done", busy, 1'b0);
    repeat (5) @(negedge clk);
    check("finish_sticky", oem_finish, 1'b1);
  endtask

  task automatic do_reset();
    #2;
    exp_bits.delete();
    exp_wr.delete();
    b_model = 0;
    reset = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; pi_data = '0; pi_length = '0;
    pi_fill = 1'b0; pi_msb = 1'b0; pi_low = 1'b0; pi_end = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_so_valid", so_valid, 1'b0);
    check("rst_so_data", so_data, 1'b0);
    check("rst_dataout", oem_dataout, 8'h00);
    check("rst_addr", oem_addr, '0);
    check("rst_strobes", {odd_wr, even_wr}, '0);
    check("rst_finish", oem_finish, 1'b0);
    reset = 1'b0;

    // Directed frames from the test plan, then a load issued while busy.
    send(16'hA5C3, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    send(16'h3C00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    send(16'hFFFF, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    send(16'hFFFF, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    send(16'h1234, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      send_random(1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset in the cycle of a byte strobe, in the middle of a frame.
    begin
      int k;
      k = ec + 1;
      load = 1'b1; pi_data = 16'hBEEF; pi_length = 2'b11; pi_fill = 1'b1; pi_msb = 1'b1;
      model_frame(k, 16'hBEEF, 2'b11, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      load = 1'b0;
      while (ec < k + 8) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst_so_valid", so_valid, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_strobes", {odd_wr, even_wr}, '0);
      check("arst_dataout", oem_dataout, 8'h00);
      exp_bits.delete();
      exp_wr.delete();
      b_model = 0;
      @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
    end

    // Three frames restarting at byte 0, then zero-fill to the last byte.
    send(16'hA5C3, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    send_random(1'b0);
    send_random(1'b0);
    do_end();

    // load is ignored in DONE.
    load = 1'b1;
    pi_length = 2'b11;
    repeat (3) @(negedge clk);
    load = 1'b0;
    repeat (10) @(negedge clk);
    check("done_no_valid", so_valid, 1'b0);
    check("done_finish", oem_finish, 1'b1);

    // Overflow: run past the last byte, then pi_end goes straight to DONE.
    do_reset();
    check("reset_clears_finish", oem_finish, 1'b0);
    for (int i = 0; i < 200 && b_model < TOTAL; i++) send_random(1'b0);
    for (int i = 0; i < 3; i++) send(DW'($urandom), 2'b11, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
    do_end();

    repeat (3) @(negedge clk);
    check("bits_drained", exp_bits.size(), 0);
    check("writes_drained", exp_wr.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
